ls166_pixel_shifter: RTL and testbench

- Parallel-in/serial-out graphics shifter modelled on a pair of cascaded 74LS166 chips, one per bitplane.
- Takes tile/sprite ROM bytes from the fetch logic and serialises them into per-pixel plane bits, with horizontal flip and attribute latching.
- Output pixels are gated by the background window enable and feed the 74LS153-style priority/colour muxes.
- Acts as the consuming end of the fetch pipeline: it requests each next byte group, so fetch and shift stay lock-stepped without gaps.

---
 rtl/ls166_pixel_shifter.sv | 84 ++++++++
 tb/tb_ls166_pixel_shifter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls166_pixel_shifter.sv
// Cascaded 74LS166-style plane serialiser: one pixel per ce, first pixel visible 1 ce after load.
// Pulls groups with need_data/load_req; a missing reload at the last phase ends the run with underrun.
module ls166_pixel_shifter #(
  parameter int PLANES = 2,
  parameter int WIDTH  = 8,
  parameter int PAL_W  = 4
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     ce,
  input  logic                     load_req,
  input  logic [PLANES*WIDTH-1:0]  d,
  input  logic                     flip,
  input  logic [PAL_W-1:0]         pal_in,
  input  logic                     win_en,
  output logic [PLANES-1:0]        pix_out,
  output logic [PAL_W-1:0]         pal_out,
  output logic                     opaque,
  output logic                     need_data,
  output logic                     underrun,
  output logic                     busy
);

  localparam int            PW   = $clog2(WIDTH);
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0] NEAR = PW'(WIDTH - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state;
  logic [PW-1:0]                phase;
  logic [PLANES-1:0][WIDTH-1:0] sr;
  logic                         flip_q;
  logic [PAL_W-1:0]             pal_q;
  logic [PLANES-1:0]            head;
  logic                         at_last;
  logic                         show;

  assign at_last = (state == RUN) && (phase == LAST);

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state  <= IDLE;
      phase  <= '0;
      sr     <= '0;
      flip_q <= 1'b0;
      pal_q  <= '0;
    end else if (ce) begin
      // A reload is only honoured from IDLE or on the last pixel, so the seam stays gapless.
      if ((state == IDLE || at_last) && load_req) begin
        state  <= RUN;
        phase  <= '0;
        sr     <= d;
        flip_q <= flip;
        pal_q  <= pal_in;
      end else if (at_last) begin
        state <= IDLE;
        phase <= '0;
        sr    <= '0;
      end else if (state == RUN) begin
        phase <= phase + PW'(1);
        for (int p = 0; p < PLANES; p++) begin
          sr[p] <= flip_q ? (sr[p] >> 1) : (sr[p] << 1);
        end
      end
    end
  end

  always_comb begin
    head = '0;
    for (int p = 0; p < PLANES; p++) begin
      head[p] = flip_q ? sr[p][0] : sr[p][WIDTH-1];
    end
  end

  assign busy      = (state == RUN);
  assign show      = busy & win_en;
  assign pix_out   = head & {PLANES{show}};
  assign pal_out   = show ? pal_q : '0;
  assign opaque    = |pix_out;
  assign need_data = ce & busy & (phase == NEAR);
  assign underrun  = ce & at_last & ~load_req;

endmodule

// File: tb/tb_ls166_pixel_shifter.sv
// Bench for ls166_pixel_shifter: directed scenarios plus random traffic against a pixel-index model.
module tb_ls166_pixel_shifter;

  logic        clk = 1'b0;
  logic        n_clr;
  logic        ce;
  logic        load_req;
  logic [15:0] d;
  logic        flip;
  logic [3:0]  pal_in;
  logic        win_en;
  logic [1:0]  pix_out;
  logic [3:0]  pal_out;
  logic        opaque;
  logic        need_data;
  logic        underrun;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Model: the group is a list of 8 pixels indexed by position, not a shift register.
  bit          m_busy;
  int          m_idx;
  logic [15:0] m_d;
  bit          m_flip;
  logic [3:0]  m_pal;

  ls166_pixel_shifter dut (
    .clk(clk), .n_clr(n_clr), .ce(ce), .load_req(load_req), .d(d), .flip(flip),
    .pal_in(pal_in), .win_en(win_en), .pix_out(pix_out), .pal_out(pal_out),
    .opaque(opaque), .need_data(need_data), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic model_bit(input int p, input int i);
    int pos;
    pos = m_flip ? i : 7 - i;
    return m_d[p*8 + pos];
  endfunction

  function automatic logic [9:0] expect_v();
    logic [1:0] px;
    logic [3:0] pl;
    for (int p = 0; p < 2; p++) px[p] = m_busy && win_en && model_bit(p, m_idx);
    pl = (m_busy && win_en) ? m_pal : 4'h0;
    return {px, pl, |px, ce && m_busy && m_idx == 6,
            ce && m_busy && m_idx == 7 && !load_req, m_busy};
  endfunction

  function automatic logic [9:0] obs_v();
    return {pix_out, pal_out, opaque, need_data, underrun, busy};
  endfunction

  task automatic drive(input logic c, input logic lr, input logic [15:0] dd,
                       input logic f, input logic [3:0] pl, input logic w);
    ce = c; load_req = lr; d = dd; flip = f; pal_in = pl; win_en = w;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_clr && ce) begin
      if (!m_busy || m_idx == 7) begin
        if (load_req) begin
          m_busy = 1; m_idx = 0; m_d = d; m_flip = flip; m_pal = pal_in;
        end else begin
          m_busy = 0; m_idx = 0;
        end
      end else begin
        m_idx++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_clr = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    m_busy = 0; m_idx = 0; m_d = '0; m_flip = 0; m_pal = '0;
    vectors++;
    if (obs_v() !== 10'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want %h", obs_v(), 10'h0);
    end
    @(negedge clk);
    n_clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    pat = 8'b1010_0101;
    drive(1'b1, 1'b1, 16'h00A5, 1'b0, 4'h3, 1'b1);
    vectors++;
    if (obs_v() !== expect_v()) begin
      miscompares++; $display("FAIL basic_load got %h want %h", obs_v(), expect_v());
    end
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
      vectors++;
      if (obs_v() !== expect_v()) begin
        miscompares++; $display("FAIL basic_model px%0d got %h want %h", i, obs_v(), expect_v());
      end
      vectors++;
      if (i < 8 && (pix_out[0] !== pat[7-i] || pal_out !== 4'h3 || busy !== 1'b1 || underrun !== (i == 7))) begin
        miscompares++;
        $display("FAIL basic_seq px%0d got pix0=%b pal=%h busy=%b und=%b want pix0=%b pal=3 busy=1 und=%b",
                 i, pix_out[0], pal_out, busy, underrun, pat[7-i], i == 7);
      end
      if (i == 8 && (busy !== 1'b0 || pix_out !== 2'b00 || underrun !== 1'b0)) begin
        miscompares++;
        $display("FAIL basic_end got busy=%b pix=%b und=%b want 0 0 0", busy, pix_out, underrun);
      end
      tick();
    end
  endtask

  task automatic test_flip();
    logic [15:0] dv [2];
    logic [7:0]  p0 [2];
    logic [7:0]  p1 [2];
    dv[0] = 16'h00A5; p0[0] = 8'b1010_0101; p1[0] = 8'h00;
    dv[1] = 16'hF001; p0[1] = 8'b1000_0000; p1[1] = 8'b0000_1111;
    for (int g = 0; g < 2; g++) begin
      drive(1'b1, 1'b1, dv[g], 1'b1, 4'h9, 1'b1);
      tick();
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
        vectors++;
        if (obs_v() !== expect_v()) begin
          miscompares++; $display("FAIL flip_model g%0d px%0d got %h want %h", g, i, obs_v(), expect_v());
        end
        vectors++;
        if (pix_out !== {p1[g][7-i], p0[g][7-i]}) begin
          miscompares++;
          $display("FAIL flip_seq g%0d px%0d got %b want %b", g, i, pix_out, {p1[g][7-i], p0[g][7-i]});
        end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dv [5];
    logic [3:0]  pv [5];
    for (int g = 0; g < 5; g++) begin
      dv[g] = (g % 2 == 0) ? 16'hFFFF : 16'h0000;
      pv[g] = 4'($urandom_range(0, 15));
    end
    drive(1'b1, 1'b1, dv[0], 1'b0, pv[0], 1'b1);
    tick();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, (i == 7) && (g < 3), dv[g+1], 1'($urandom_range(0, 1)) & (i != 7), pv[g+1], 1'b1);
        vectors++;
        if (obs_v() !== expect_v()) begin
          miscompares++; $display("FAIL b2b_model g%0d px%0d got %h want %h", g, i, obs_v(), expect_v());
        end
        vectors++;
        if (need_data !== (i == 6) || underrun !== (g == 3 && i == 7) ||
            pix_out !== ((g % 2 == 0) ? 2'b11 : 2'b00) || pal_out !== pv[g]) begin
          miscompares++;
          $display("FAIL b2b_seq g%0d px%0d got nd=%b und=%b pix=%b pal=%h want pal=%h",
                   g, i, need_data, underrun, pix_out, pal_out, pv[g]);
        end
        tick();
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] dv;
    logic [7:0]  pat;
    dv  = 16'($urandom());
    pat = dv[7:0];
    drive(1'b1, 1'b1, dv, 1'b0, 4'h5, 1'b1);
    tick();
    for (int k = 0; k < 25; k++) begin
      drive(k % 3 == 2, k >= 9 && k <= 11, ~dv, 1'b1, 4'hA, 1'b1);
      vectors++;
      if (obs_v() !== expect_v()) begin
        miscompares++; $display("FAIL stall_model clk%0d got %h want %h", k, obs_v(), expect_v());
      end
      vectors++;
      if (k < 24 && (pix_out[0] !== pat[7 - k/3] || pal_out !== 4'h5 || underrun !== (k == 23))) begin
        miscompares++;
        $display("FAIL stall_seq clk%0d got pix0=%b pal=%h und=%b want pix0=%b pal=5 und=%b",
                 k, pix_out[0], pal_out, underrun, pat[7 - k/3], k == 23);
      end
      if (k == 24 && busy !== 1'b0) begin
        miscompares++; $display("FAIL stall_end got busy=%b want 0", busy);
      end
      tick();
    end
  endtask

  task automatic test_window();
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0, 4'hC, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, !(i >= 2 && i <= 4));
      vectors++;
      if (obs_v() !== expect_v()) begin
        miscompares++; $display("FAIL win_model px%0d got %h want %h", i, obs_v(), expect_v());
      end
      vectors++;
      if ((i >= 2 && i <= 4) ? (pix_out !== 2'b00 || pal_out !== 4'h0 || opaque !== 1'b0)
                             : (pix_out !== 2'b11 || pal_out !== 4'hC || opaque !== 1'b1)) begin
        miscompares++;
        $display("FAIL win_seq px%0d got pix=%b pal=%h opq=%b", i, pix_out, pal_out, opaque);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] dv;
    drive(1'b1, 1'b1, 16'hFFFF, 1'b0, 4'h7, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
      tick();
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    #1 n_clr = 1'b0;
    #1;
    m_busy = 0; m_idx = 0;
    vectors++;
    if (obs_v() !== 10'h0) begin
      miscompares++; $display("FAIL arst_outputs got %h want %h", obs_v(), 10'h0);
    end
    @(negedge clk);
    n_clr = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL arst_idle got busy=%b want 0", busy);
    end
    dv = 16'($urandom()) | 16'h8080;
    drive(1'b1, 1'b1, dv, 1'b0, 4'h2, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0, 1'b0, 4'h0, 1'b1);
      vectors++;
      if (obs_v() !== expect_v() || pix_out !== {dv[15-i], dv[7-i]}) begin
        miscompares++;
        $display("FAIL arst_restart px%0d got %h pix=%b want %h pix=%b", i, obs_v(), pix_out,
                 expect_v(), {dv[15-i], dv[7-i]});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom()),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 4) != 0);
      vectors++;
      if (obs_v() !== expect_v()) begin
        miscompares++; $display("FAIL rand_model clk%0d got %h want %h", k, obs_v(), expect_v());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_back_to_back();
    test_stall();
    test_window();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
